// File: rtl/time_counter_pkg.sv
// Shared definitions for the multi-channel elapsed-time counter.
//   state_t : per-channel FSM state encoding
//   pw()    : width of a counter indexing n values, never below 1 bit
package time_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   function automatic int unsigned pw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_time_counter_if.sv
// Host-side bundle of the multi-channel time counter.
//   START/STOP/CLEAR : per-channel control requests (host -> counter)
//   RDSEL            : channel select for TIMEELAPSED (host -> counter)
//   TIMEELAPSED      : registered time of the selected channel
//   TIME_ALL         : all channel times, channel i at [i*W +: W]
//   RUNNING/OVFL/ALARM : per-channel status flags
interface multi_time_counter_if #(
   parameter int unsigned NCH = 2,
   parameter int unsigned W   = 16
);
   localparam int unsigned SW = time_counter_pkg::pw(NCH);

   logic [NCH-1:0]   START;
   logic [NCH-1:0]   STOP;
   logic [NCH-1:0]   CLEAR;
   logic [SW-1:0]    RDSEL;
   logic [W-1:0]     TIMEELAPSED;
   logic [NCH*W-1:0] TIME_ALL;
   logic [NCH-1:0]   RUNNING;
   logic [NCH-1:0]   OVFL;
   logic [NCH-1:0]   ALARM;

   modport master (
      output START, STOP, CLEAR, RDSEL,
      input  TIMEELAPSED, TIME_ALL, RUNNING, OVFL, ALARM
   );

   modport slave (
      input  START, STOP, CLEAR, RDSEL,
      output TIMEELAPSED, TIME_ALL, RUNNING, OVFL, ALARM
   );
endinterface

// File: rtl/time_counter_channel.sv
// One elapsed-time channel: FSM, prescaler, time register, sticky flags.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i, stop_i, clear_i : control requests (priority clear > stop > start)
//   time_o    : elapsed time in units of DIV clocks
//   running_o : channel is in RUN
//   ovfl_o    : sticky overflow
//   alarm_o   : sticky alarm, time reached ALARM_VAL through a tick
module time_counter_channel
   import time_counter_pkg::*;
#(
   parameter int unsigned DIV       = 4,
   parameter int unsigned W         = 16,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned ALARM_VAL = 0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         stop_i,
   input  logic         clear_i,
   output logic [W-1:0] time_o,
   output logic         running_o,
   output logic         ovfl_o,
   output logic         alarm_o
);
   localparam int unsigned     PW      = pw(DIV);
   localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);
   // Thresholds not representable in W bits can never be reached.
   localparam bit              ALARM_EN = (ALARM_VAL != 0) && ((64'(ALARM_VAL) >> W) == 64'd0);
   localparam logic [W-1:0]    ALARM_W  = W'(ALARM_VAL);

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [W-1:0]  time_q, time_d;
   logic          ovfl_q, ovfl_d;
   logic          alarm_q, alarm_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         time_q  <= '0;
         ovfl_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         time_q  <= time_d;
         ovfl_q  <= ovfl_d;
         alarm_q <= alarm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      time_d  = time_q;
      ovfl_d  = ovfl_q;
      alarm_d = alarm_q;
      if (clear_i) begin
         state_d = ST_IDLE;
         pre_d   = '0;
         time_d  = '0;
         ovfl_d  = 1'b0;
         alarm_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i && !stop_i) begin
                  state_d = ST_RUN;
                  pre_d   = '0;
                  time_d  = '0;
               end
            end
            ST_RUN: begin
               // The cycle that samples STOP still counts; a saturating
               // tick in that same cycle takes the channel to HALT instead.
               if (stop_i) state_d = ST_PAUSE;
               if (pre_q == PRE_MAX) begin
                  pre_d = '0;
                  if (time_q != '1) begin
                     time_d = time_q + W'(1);
                     if (ALARM_EN && (time_d == ALARM_W)) alarm_d = 1'b1;
                  end else if (SATURATE != 0) begin
                     pre_d   = pre_q;
                     ovfl_d  = 1'b1;
                     state_d = ST_HALT;
                  end else begin
                     time_d = '0;
                     ovfl_d = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (start_i && !stop_i) state_d = ST_RUN;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign time_o    = time_q;
   assign running_o = (state_q == ST_RUN);
   assign ovfl_o    = ovfl_q;
   assign alarm_o   = alarm_q;

endmodule

// File: rtl/multi_time_counter.sv
// Multi-channel elapsed-time counter.
//   MCLK  : master clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : host bundle (slave side): START/STOP/CLEAR/RDSEL in,
//           TIMEELAPSED/TIME_ALL/RUNNING/OVFL/ALARM out
module multi_time_counter
   import time_counter_pkg::*;
#(
   parameter int unsigned NCH       = 2,
   parameter int unsigned DIV       = 4,
   parameter int unsigned W         = 16,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned ALARM_VAL = 0
) (
   input  logic MCLK,
   input  logic RESET,
   multi_time_counter_if.slave bus
);
   localparam int unsigned SW = pw(NCH);

   logic [W-1:0] time_ch [NCH];
   logic [W-1:0] sel_d, sel_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      time_counter_channel #(
         .DIV       (DIV),
         .W         (W),
         .SATURATE  (SATURATE),
         .ALARM_VAL (ALARM_VAL)
      ) u_ch (
         .clk_i     (MCLK),
         .rst_i     (RESET),
         .start_i   (bus.START[g]),
         .stop_i    (bus.STOP[g]),
         .clear_i   (bus.CLEAR[g]),
         .time_o    (time_ch[g]),
         .running_o (bus.RUNNING[g]),
         .ovfl_o    (bus.OVFL[g]),
         .alarm_o   (bus.ALARM[g])
      );
      assign bus.TIME_ALL[g*W +: W] = time_ch[g];
   end

   // Out-of-range selects fall through the loop and read as zero.
   always_comb begin
      sel_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (bus.RDSEL == SW'(i)) sel_d = time_ch[i];
      end
   end

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) sel_q <= '0;
      else       sel_q <= sel_d;
   end

   assign bus.TIMEELAPSED = sel_q;

endmodule

// File: tb/tb_multi_time_counter.sv
module tb_multi_time_counter;
   logic MCLK;
   logic RESET;
   int unsigned total = 0;
   int unsigned bad   = 0;

   // A: basic count / pause / async reset. B: saturate + alarm. C: wrap, 3 channels.
   multi_time_counter_if #(.NCH(2), .W(8)) ifa ();
   multi_time_counter_if #(.NCH(2), .W(8)) ifb ();
   multi_time_counter_if #(.NCH(3), .W(8)) ifc ();

   multi_time_counter #(.NCH(2), .DIV(4), .W(8), .SATURATE(1), .ALARM_VAL(0)) dut_a (
      .MCLK(MCLK), .RESET(RESET), .bus(ifa));
   multi_time_counter #(.NCH(2), .DIV(1), .W(8), .SATURATE(1), .ALARM_VAL(3)) dut_b (
      .MCLK(MCLK), .RESET(RESET), .bus(ifb));
   multi_time_counter #(.NCH(3), .DIV(1), .W(8), .SATURATE(0), .ALARM_VAL(0)) dut_c (
      .MCLK(MCLK), .RESET(RESET), .bus(ifc));

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge MCLK);
         #1;
      end
   endtask

   initial begin
      RESET = 1'b1;
      ifa.START = '0; ifa.STOP = '0; ifa.CLEAR = '0; ifa.RDSEL = '0;
      ifb.START = '0; ifb.STOP = '0; ifb.CLEAR = '0; ifb.RDSEL = '0;
      ifc.START = '0; ifc.STOP = '0; ifc.CLEAR = '0; ifc.RDSEL = '0;

      // Reset: 3 cycles, then 20 idle cycles with all outputs zero
      step(3);
      RESET = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("rst_a", {ifa.TIMEELAPSED, ifa.TIME_ALL, ifa.RUNNING, ifa.OVFL, ifa.ALARM}, 64'd0);
      end
      check("rst_b", {ifb.TIMEELAPSED, ifb.TIME_ALL, ifb.RUNNING, ifb.OVFL, ifb.ALARM}, 64'd0);
      check("rst_c", {ifc.TIMEELAPSED, ifc.TIME_ALL, ifc.RUNNING, ifc.OVFL, ifc.ALARM}, 64'd0);

      // Basic count on A (DIV=4): START sampled at edge k
      ifa.START = 2'b01;
      step(1);
      ifa.START = 2'b00;
      check("basic_run", ifa.RUNNING, 2'b01);
      step(3);
      check("basic_k3", ifa.TIME_ALL[7:0], 8'd0);
      step(1);
      check("basic_k4", ifa.TIME_ALL[7:0], 8'd1);
      check("basic_te_k4", ifa.TIMEELAPSED, 8'd0);
      step(1);
      check("basic_te_k5", ifa.TIMEELAPSED, 8'd1);
      step(15);
      check("basic_k20", ifa.TIME_ALL[7:0], 8'd5);
      check("basic_te_k20", ifa.TIMEELAPSED, 8'd4);
      check("basic_ch1", ifa.TIME_ALL[15:8], 8'd0);
      check("basic_run2", ifa.RUNNING, 2'b01);

      // Pause 2 edges after the tick at k+20; prescaler sits at 2
      step(1);
      ifa.STOP = 2'b01;
      step(1);
      ifa.STOP = 2'b00;
      check("pause_run", ifa.RUNNING, 2'b00);
      step(10);
      check("pause_hold", ifa.TIME_ALL[7:0], 8'd5);
      ifa.START = 2'b01;
      step(1);
      ifa.START = 2'b00;
      check("resume_run", ifa.RUNNING, 2'b01);
      step(1);
      check("resume_r1", ifa.TIME_ALL[7:0], 8'd5);
      step(1);
      check("resume_r2", ifa.TIME_ALL[7:0], 8'd6);

      // Asynchronous reset mid-count, away from any clock edge
      step(1);
      #2 RESET = 1'b1;
      #1;
      check("async_rst_time", ifa.TIME_ALL, 16'd0);
      check("async_rst_run", ifa.RUNNING, 2'b00);
      check("async_rst_te", ifa.TIMEELAPSED, 8'd0);
      step(2);
      RESET = 1'b0;
      step(5);
      check("post_rst_idle", {ifa.TIME_ALL, ifa.RUNNING}, 64'd0);

      // Saturate on B ch0 (DIV=1), alarm at 3
      ifb.START = 2'b01;
      step(1);
      ifb.START = 2'b00;
      step(2);
      check("sat_t2", ifb.TIME_ALL[7:0], 8'd2);
      check("sat_alarm_pre", ifb.ALARM, 2'b00);
      step(1);
      check("sat_t3", ifb.TIME_ALL[7:0], 8'd3);
      check("sat_alarm", ifb.ALARM, 2'b01);
      step(252);
      check("sat_t255", ifb.TIME_ALL[7:0], 8'd255);
      check("sat_ovfl_pre", ifb.OVFL, 2'b00);
      check("sat_run_pre", ifb.RUNNING, 2'b01);
      step(1);
      check("sat_ovfl", ifb.OVFL, 2'b01);
      check("sat_halt", ifb.RUNNING, 2'b00);
      check("sat_hold", ifb.TIME_ALL[7:0], 8'd255);
      step(3);
      ifb.START = 2'b01;
      step(2);
      ifb.START = 2'b00;
      check("halt_start", {ifb.RUNNING, ifb.TIME_ALL[7:0]}, {2'b00, 8'd255});
      ifb.CLEAR = 2'b01;
      step(1);
      ifb.CLEAR = 2'b00;
      check("sat_clear", {ifb.TIME_ALL, ifb.RUNNING, ifb.OVFL, ifb.ALARM}, 64'd0);

      // Alarm and priorities on B ch1
      ifb.START = 2'b10;
      step(1);
      ifb.START = 2'b00;
      step(2);
      check("alm_t2", {ifb.TIME_ALL[15:8], ifb.ALARM}, {8'd2, 2'b00});
      step(1);
      check("alm_t3", {ifb.TIME_ALL[15:8], ifb.ALARM}, {8'd3, 2'b10});
      ifb.CLEAR = 2'b10; ifb.STOP = 2'b10; ifb.START = 2'b10;
      step(1);
      ifb.CLEAR = 2'b00; ifb.STOP = 2'b00; ifb.START = 2'b00;
      check("prio_clear", {ifb.TIME_ALL, ifb.RUNNING, ifb.OVFL, ifb.ALARM}, 64'd0);
      ifb.STOP = 2'b10; ifb.START = 2'b10;
      step(1);
      ifb.STOP = 2'b00; ifb.START = 2'b00;
      check("idle_ss_run", ifb.RUNNING, 2'b00);
      step(3);
      check("idle_ss_time", ifb.TIME_ALL, 16'd0);

      // Wrap on C ch0 (DIV=1, SATURATE=0)
      ifc.START = 3'b001;
      step(1);
      ifc.START = 3'b000;
      step(255);
      check("wrap_t255", {ifc.TIME_ALL[7:0], ifc.OVFL}, {8'd255, 3'b000});
      step(1);
      check("wrap_t0", {ifc.TIME_ALL[7:0], ifc.OVFL, ifc.RUNNING}, {8'd0, 3'b001, 3'b001});
      step(3);
      check("wrap_t3", {ifc.TIME_ALL[7:0], ifc.OVFL}, {8'd3, 3'b001});
      ifc.RDSEL = 2'd3;
      step(1);
      check("rdsel_oob", ifc.TIMEELAPSED, 8'd0);
      ifc.RDSEL = 2'd0;
      step(1);
      check("rdsel_ch0", ifc.TIMEELAPSED, 8'd4);
      ifc.RDSEL = 2'd1;
      step(1);
      check("rdsel_ch1", ifc.TIMEELAPSED, 8'd0);
      check("wrap_t6", ifc.TIME_ALL[7:0], 8'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end
endmodule
